mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 5-stage 64-bit RISC-V pipeline. It sits directly downstream of the EX/MEM register and consumes every EX/MEM field. It performs doubleword loads and stores against an internal data memory with a configurable multi-cycle access latency, stalling upstream for the duration. It resolves the branch decision and presents registered results to write-back.

## Interface
- MEM_BYTES, 512: data memory size in bytes; power of two, ≥ 8.
- MEM_LATENCY, 2: cycles per load/store access; ≥ 1.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- EX_MEM_rd  in  5  destination register.
- EX_MEM_readData2  in  64  store data.
- EX_MEM_ALU_result  in  64  byte address for loads/stores; pass-through result otherwise.
- EX_MEM_zero  in  1  ALU zero flag.
- EX_MEM_pcOut  in  64  branch target.
- EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_regWrite, EX_MEM_MemtoReg  in  1 each  control.
- pc_src  out  1  combinational: EX_MEM_Branch & EX_MEM_zero.
- branch_target  out  64  combinational: EX_MEM_pcOut.
- mem_stall  out  1  combinational: the memory access is incomplete; upstream must hold.
- MEM_WB_rd  out  5  registered.
- MEM_WB_readData  out  64  registered load data.
- MEM_WB_ALU_result  out  64  registered.
- MEM_WB_regWrite, MEM_WB_MemtoReg  out  1 each  registered.

## Operation
- Word index is EX_MEM_ALU_result[log2(MEM_BYTES)-1:3]. Address bits [2:0] are ignored. Upper bits wrap, so the address is taken modulo MEM_BYTES. Storage is 64-bit little-endian doublewords.
- A memory request (`req`) is MemRead | MemWrite.
- FSM states:
  - IDLE → ACCESS when `req` and MEM_LATENCY > 1. The counter loads MEM_LATENCY-2.
  - ACCESS, counter > 0: decrement.
  - ACCESS, counter == 0: this is the completion cycle; return to IDLE at the next edge.
- Completion cycle:
  - IDLE with `req` when MEM_LATENCY == 1.
  - ACCESS with counter == 0.
- mem_stall = `req` & not completion cycle.
  - Stall lasts exactly MEM_LATENCY-1 cycles per access.
  - Requests with no memory op never stall.
- Inputs must be held stable while mem_stall = 1. Inputs changing mid-access is a bench error, not a design case.
- At the completion edge:
  - Store writes mem[idx] = readData2, exactly once per access.
  - Load captures mem[idx] into MEM_WB_readData.
  - Simultaneous MemRead and MemWrite: the read returns the pre-write word and the write still occurs.
- MEM/WB register update on every edge:
  - mem_stall = 1: capture a bubble, i.e. all MEM_WB outputs = 0, so write-back never fires twice.
  - Otherwise: capture rd, ALU_result, regWrite, MemtoReg, and the load data. Load data is 0 when MemRead = 0.
- pc_src and branch_target are unaffected by the FSM state.

## Timing
- Reset (synchronous) forces:
  - state IDLE, counter 0;
  - all MEM_WB outputs 0;
  - every memory word 0.
- Reset asserted mid-access aborts it; no write occurs at that edge.
- Reset has priority over every other event.
- Non-memory instruction latency: 1 cycle from EX/MEM to MEM/WB.
- Load/store latency: MEM_LATENCY cycles from first presentation to MEM_WB valid.
- Back-to-back accesses: the next request may be presented in the cycle after completion. The FSM is in IDLE at that point, so the new access takes a full MEM_LATENCY.
- Combinational outputs (pc_src, branch_target, mem_stall) have no registered path from inputs to outputs other than through state.

## Structure
- Shared package pipeline_pkg holds:
  - XLEN = 64, REG_ADDR_W = 5;
  - mem-FSM state typedef {IDLE, ACCESS}.
- Counter width is $clog2(MEM_LATENCY), minimum 1.
- One sub-module, data_memory:
  - parameterised word array;
  - synchronous clear on reset;
  - single write port and single read port, read-before-write;
  - write-enable driven by the completion strobe.
- FSM, stall logic and the MEM/WB register stay in mem_wb_stage.

## Test plan
- Reset, then ALU result passthrough with MEM_LATENCY = 2: rd = 5, ALU_result = 0x1234, regWrite = 1 → next cycle MEM_WB_rd = 5, MEM_WB_ALU_result = 0x1234, mem_stall never high.
- Store then load, MEM_LATENCY = 2: store addr 0x10, data 0xDEADBEEF_CAFEF00D → mem_stall high 1 cycle, bubble in MEM/WB. Then load addr 0x10, rd = 7 → MEM_WB_readData = 0xDEADBEEF_CAFEF00D, MEM_WB_rd = 7 after 2 cycles.
- Wrap and alignment: store 0x55 to addr 0x203 with MEM_BYTES = 512 → load from addr 0x000 returns 0x55.
- MEM_LATENCY = 4 instance: load → mem_stall high exactly 3 cycles, MEM_WB outputs 0 during those 3 cycles, data valid at cycle 4. MEM_LATENCY = 1 instance: never stalls.
- Reset mid-access: store to 0x08 issued, reset asserted on the stall cycle → a subsequent load from 0x08 returns 0 and the FSM is in IDLE.
- Branch: Branch = 1, zero = 1, pcOut = 0x400 → pc_src = 1, branch_target = 0x400 in the same cycle. With zero = 0 → pc_src = 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 64-bit RISC-V pipeline stages.
package pipeline_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Doubleword data memory: synchronous clear, one write port, one
// asynchronous read port that returns the pre-write word at a write edge.
module data_memory
    import pipeline_pkg::*;
#(
    parameter int WORDS = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with multi-cycle data memory, branch resolution
// and the MEM/WB pipeline register.
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int MEM_BYTES   = 512,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
    input  logic [XLEN-1:0]       EX_MEM_readData2,
    input  logic [XLEN-1:0]       EX_MEM_ALU_result,
    input  logic                  EX_MEM_zero,
    input  logic [XLEN-1:0]       EX_MEM_pcOut,
    input  logic                  EX_MEM_Branch,
    input  logic                  EX_MEM_MemRead,
    input  logic                  EX_MEM_MemWrite,
    input  logic                  EX_MEM_regWrite,
    input  logic                  EX_MEM_MemtoReg,
    output logic                  pc_src,
    output logic [XLEN-1:0]       branch_target,
    output logic                  mem_stall,
    output logic [REG_ADDR_W-1:0] MEM_WB_rd,
    output logic [XLEN-1:0]       MEM_WB_readData,
    output logic [XLEN-1:0]       MEM_WB_ALU_result,
    output logic                  MEM_WB_regWrite,
    output logic                  MEM_WB_MemtoReg
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 8;
    localparam int IDX_W = (AW > 3) ? AW - 3 : 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             req;
    logic             complete;
    logic [IDX_W-1:0] word_idx;
    logic [XLEN-1:0]  rdata;

    // A single-doubleword memory has no index bits at all.
    generate
        if (AW > 3) begin : g_idx
            assign word_idx = EX_MEM_ALU_result[AW-1:3];
        end else begin : g_idx_single
            assign word_idx = '0;
        end
    endgenerate

    assign req           = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign mem_stall     = req & ~complete;
    assign pc_src        = EX_MEM_Branch & EX_MEM_zero;
    assign branch_target = EX_MEM_pcOut;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (MEM_LATENCY == 1) begin
                        complete = 1'b1;
                    end else begin
                        state_next = ACCESS;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    data_memory #(
        .WORDS(WORDS),
        .IDX_W(IDX_W)
    ) u_dmem (
        .clk  (clk),
        .reset(reset),
        .we   (complete & EX_MEM_MemWrite),
        .idx  (word_idx),
        .wdata(EX_MEM_readData2),
        .rdata(rdata)
    );

    // A stalled cycle writes a bubble so write-back fires once per instruction.
    always_ff @(posedge clk) begin
        if (reset || mem_stall) begin
            MEM_WB_rd         <= '0;
            MEM_WB_readData   <= '0;
            MEM_WB_ALU_result <= '0;
            MEM_WB_regWrite   <= 1'b0;
            MEM_WB_MemtoReg   <= 1'b0;
        end else begin
            MEM_WB_rd         <= EX_MEM_rd;
            MEM_WB_readData   <= EX_MEM_MemRead ? rdata : '0;
            MEM_WB_ALU_result <= EX_MEM_ALU_result;
            MEM_WB_regWrite   <= EX_MEM_regWrite;
            MEM_WB_MemtoReg   <= EX_MEM_MemtoReg;
        end
    end

endmodule
